sync_fifo_ext: RTL and testbench

Parametrised single-clock FIFO, next generation of the team's synchronous FIFO. Adds arbitrary (non-power-of-2) depth, a selectable first-word-fall-through (FWFT) read mode and programmable almost-full/almost-empty flags. Also adds a synchronous flush, registered error pulses and a peak-occupancy watermark. Used as the general buffering element between pipeline stages in the same clock domain.

---
 rtl/sync_fifo_ext.sv | 114 +++++++++++
 tb/tb_sync_fifo_ext.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with arbitrary depth, optional first-word-fall-through read, programmable
// almost flags, flush, error pulses and peak watermark; full/empty reject writes/reads outright.
module sync_fifo_ext #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 12,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    localparam int PTR_W        = $clog2(DEPTH),
    localparam int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      data_cnt,
    output logic [CNT_W-1:0]      max_cnt,
    output logic                  wr_err,
    output logic                  rd_err
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      cnt_nxt;
    logic                  wr_acc;
    logic                  rd_acc;

    assign empty        = (data_cnt == '0);
    assign full         = (data_cnt == CNT_W'(DEPTH));
    assign almost_full  = (data_cnt >= CNT_W'(AFULL_THRESH));
    assign almost_empty = (data_cnt <= CNT_W'(AEMPTY_THRESH));

    // Flush masks both requests so the flush cycle neither moves data nor raises errors.
    assign wr_acc = wr_en & ~full & ~flush;
    assign rd_acc = rd_en & ~empty & ~flush;

    always_comb begin
        cnt_nxt = data_cnt;
        if (wr_acc && !rd_acc)
            cnt_nxt = data_cnt + 1'b1;
        else if (rd_acc && !wr_acc)
            cnt_nxt = data_cnt - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            data_cnt <= '0;
            max_cnt  <= '0;
            wr_err   <= 1'b0;
            rd_err   <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            data_cnt <= '0;
            max_cnt  <= '0;
            wr_err   <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            // Explicit wrap compare: DEPTH need not be a power of two.
            if (wr_acc)
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (rd_acc)
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            data_cnt <= cnt_nxt;
            if (cnt_nxt > max_cnt)
                max_cnt <= cnt_nxt;
            wr_err <= wr_en & full;
            rd_err <= rd_en & empty;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data  = mem[rd_ptr];
            assign rd_valid = ~empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else if (flush) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc)
                        rd_data_q <= mem[rd_ptr];
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: a standard and an FWFT instance share one stimulus stream and are
// checked against a queue model of the contents plus a scoreboard of expected registered reads.
module tb_sync_fifo_ext;

    localparam int DW    = 8;
    localparam int DEPTH = 12;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;

    logic [DW-1:0] s_rd_data, f_rd_data;
    logic          s_rd_valid, f_rd_valid;
    logic          s_empty, f_empty, s_full, f_full;
    logic          s_afull, f_afull, s_aempty, f_aempty;
    logic [CW-1:0] s_cnt, f_cnt, s_max, f_max;
    logic          s_werr, f_werr, s_rerr, f_rerr;

    always #5 clk = ~clk;

    sync_fifo_ext #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .empty(s_empty),
        .full(s_full), .almost_full(s_afull), .almost_empty(s_aempty),
        .data_cnt(s_cnt), .max_cnt(s_max), .wr_err(s_werr), .rd_err(s_rerr)
    );

    sync_fifo_ext #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .empty(f_empty),
        .full(f_full), .almost_full(f_afull), .almost_empty(f_aempty),
        .data_cnt(f_cnt), .max_cnt(f_max), .wr_err(f_werr), .rd_err(f_rerr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] sb[$];
    int            m_cnt  = 0;
    int            m_max  = 0;
    bit            m_werr = 1'b0;
    bit            m_rerr = 1'b0;
    bit            m_sval = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("cnt",        s_cnt,    m_cnt);
        chk("max",        s_max,    m_max);
        chk("empty",      s_empty,  m_cnt == 0);
        chk("full",       s_full,   m_cnt == DEPTH);
        chk("afull",      s_afull,  m_cnt >= DEPTH - 2);
        chk("aempty",     s_aempty, m_cnt <= 2);
        chk("wr_err",     s_werr,   m_werr);
        chk("rd_err",     s_rerr,   m_rerr);
        chk("std_valid",  s_rd_valid, m_sval);
        if (s_rd_valid) begin
            if (sb.size() == 0)
                chk("std_extra", s_rd_valid, 1'b0);
            else
                chk("std_data", s_rd_data, sb.pop_front());
        end
        chk("f_cnt",      f_cnt,  m_cnt);
        chk("f_max",      f_max,  m_max);
        chk("f_wr_err",   f_werr, m_werr);
        chk("f_rd_err",   f_rerr, m_rerr);
        chk("f_flags",    {f_empty, f_full, f_afull, f_aempty},
                          {m_cnt == 0, m_cnt == DEPTH, m_cnt >= DEPTH - 2, m_cnt <= 2});
        chk("fwft_valid", f_rd_valid, m_cnt != 0);
        if (m_cnt != 0)
            chk("fwft_data", f_rd_data, mq[0]);
    endtask

    // Called just after a rising edge; drives one cycle and checks state after the next edge.
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit fl);
        bit wacc, racc;
        wr_en = w; wr_data = d; rd_en = r; flush = fl;
        @(negedge clk);
        wacc = w && !fl && (m_cnt < DEPTH);
        racc = r && !fl && (m_cnt > 0);
        m_werr = w && !fl && (m_cnt == DEPTH);
        m_rerr = r && !fl && (m_cnt == 0);
        m_sval = racc;
        if (racc) begin
            chk("fwft_head", f_rd_data, mq[0]);
            sb.push_back(mq.pop_front());
        end
        if (fl) begin
            mq.delete();
            m_max = 0;
        end else if (wacc) begin
            mq.push_back(d);
        end
        m_cnt = mq.size();
        if (m_cnt > m_max)
            m_max = m_cnt;
        @(posedge clk);
        #1;
        check_all();
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_cnt",    s_cnt,    0);
        chk("rst_max",    s_max,    0);
        chk("rst_flags",  {s_empty, s_full, s_afull, s_aempty}, 4'b1001);
        chk("rst_errs",   {s_werr, s_rerr, f_werr, f_rerr}, 4'b0000);
        chk("rst_valid",  {s_rd_valid, f_rd_valid}, 2'b00);
        chk("rst_rd_data", s_rd_data, 0);
        chk("rst_f_cnt",  f_cnt,    0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        #3;
        check_reset_vals();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill to full, then one rejected write.
        for (int i = 1; i <= DEPTH; i++) step(1, DW'(i), 0, 0);
        step(1, 8'hEE, 0, 0);
        step(0, 8'h00, 0, 0);

        // Drain completely, then rejected read, then wrap check.
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        step(1, 8'hAA, 0, 0);
        step(0, 8'h00, 1, 0);

        // Simultaneous read/write at occupancy 5.
        for (int i = 0; i < 5; i++) step(1, DW'(8'h10 + i), 0, 0);
        for (int i = 0; i < 3; i++) step(1, DW'(8'h20 + i), 1, 0);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0);

        // Simultaneous at empty, then at full.
        step(1, 8'h33, 1, 0);
        for (int i = 0; i < DEPTH - 1; i++) step(1, DW'(8'h40 + i), 0, 0);
        step(1, 8'h44, 1, 0);

        // Down to 7 entries, then flush with both requests asserted.
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
        step(1, 8'h77, 1, 1);
        step(1, 8'h5A, 0, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);

        // Asynchronous reset mid-cycle with 4 entries held.
        for (int i = 0; i < 4; i++) step(1, DW'(8'h60 + i), 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals();
        mq.delete(); sb.delete();
        m_cnt = 0; m_max = 0; m_werr = 1'b0; m_rerr = 1'b0; m_sval = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, 8'h00, 1, 0);
        step(1, 8'h99, 0, 0);
        step(0, 8'h00, 1, 0);

        // Random traffic with occasional flush.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 55, DW'($urandom), $urandom_range(0, 99) < 45,
                 $urandom_range(0, 59) == 0);
        step(0, 8'h00, 0, 0);
        chk("sb_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
